// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: operation codes, stage states and the held result entry.
package alu_pkg;

    // Entry fields are sized for the widest supported configuration; narrower builds leave the upper bits zero.
    localparam int ALU_MAX_DATA_WIDTH     = 64;
    localparam int ALU_MAX_REG_ADDR_WIDTH = 16;

    typedef enum logic [3:0] {
        AND = 4'b0000,
        OR  = 4'b0001,
        ADD = 4'b0010,
        SUB = 4'b0110,
        SLT = 4'b0111,
        NOR = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } stage_state_t;

    typedef struct packed {
        logic [ALU_MAX_DATA_WIDTH-1:0]     result;
        logic                              zero;
        logic                              overflow;
        logic                              illegal;
        logic [ALU_MAX_REG_ADDR_WIDTH-1:0] dest;
    } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: turns a control code and two operands into a complete result entry.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [3:0]                controlOpALU,
    input  logic [DATA_WIDTH-1:0]     operandA,
    input  logic [DATA_WIDTH-1:0]     operandB,
    input  logic [REG_ADDR_WIDTH-1:0] destReg,
    output alu_entry_t                entry
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] res;
    logic                  ovf;
    logic                  illegal;
    logic                  lessThan;

    assign sum      = operandA + operandB;
    assign diff     = operandA - operandB;
    assign lessThan = $signed(operandA) < $signed(operandB);

    always_comb begin
        res     = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (controlOpALU)
            ADD: begin
                res = sum;
                ovf = (operandA[MSB] == operandB[MSB]) && (sum[MSB] != operandA[MSB]);
            end
            SUB: begin
                res = diff;
                ovf = (operandA[MSB] != operandB[MSB]) && (diff[MSB] != operandA[MSB]);
            end
            AND: res = operandA & operandB;
            OR:  res = operandA | operandB;
            NOR: res = ~(operandA | operandB);
            SLT: res = {{(DATA_WIDTH-1){1'b0}}, lessThan};
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        entry                             = '0;
        entry.result[MSB:0]               = res;
        entry.zero                        = (res == '0);
        entry.overflow                    = ovf;
        entry.illegal                     = illegal;
        entry.dest[REG_ADDR_WIDTH-1:0]    = destReg;
    end

endmodule

// File: rtl/alu_execute_stage.sv
// EX stage: registers ALU results toward EX/MEM through a two-entry skid buffer with flush support.
// Defining ALU_STAGE_STATS_EN adds saturating transfer counters opCount and illegalCount.
module alu_execute_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [3:0]                controlOpALU,
    input  logic [DATA_WIDTH-1:0]     operandA,
    input  logic [DATA_WIDTH-1:0]     operandB,
    input  logic [REG_ADDR_WIDTH-1:0] destReg,
    input  logic                      flush,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [DATA_WIDTH-1:0]     aluResult,
    output logic                      zeroFlag,
    output logic                      overflowFlag,
    output logic                      illegalOp,
    output logic [REG_ADDR_WIDTH-1:0] outDestReg
`ifdef ALU_STAGE_STATS_EN
    ,
    output logic [31:0]               opCount,
    output logic [15:0]               illegalCount
`endif
);

    stage_state_t state;
    alu_entry_t   coreEntry;
    alu_entry_t   outEntry;
    alu_entry_t   skidEntry;
    logic         accept;
    logic         transfer;
    logic         unusedOutEntryBits;

    alu_core #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_alu_core (
        .controlOpALU (controlOpALU),
        .operandA     (operandA),
        .operandB     (operandB),
        .destReg      (destReg),
        .entry        (coreEntry)
    );

    assign accept   = inValid & inReady;
    assign transfer = outValid & outReady;

    // Flush only clears the control state; the entry registers may keep stale data until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            outValid  <= 1'b0;
            inReady   <= 1'b1;
            outEntry  <= '0;
            skidEntry <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            outValid <= 1'b0;
            inReady  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        outEntry <= coreEntry;
                        outValid <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && transfer) begin
                        outEntry <= coreEntry;
                    end else if (accept) begin
                        skidEntry <= coreEntry;
                        inReady   <= 1'b0;
                        state     <= FULL;
                    end else if (transfer) begin
                        outValid <= 1'b0;
                        state    <= EMPTY;
                    end
                end
                FULL: begin
                    if (transfer) begin
                        outEntry <= skidEntry;
                        inReady  <= 1'b1;
                        state    <= BUSY;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    outValid <= 1'b0;
                    inReady  <= 1'b1;
                end
            endcase
        end
    end

    assign aluResult    = outEntry.result[DATA_WIDTH-1:0];
    assign zeroFlag     = outEntry.zero;
    assign overflowFlag = outEntry.overflow;
    assign illegalOp    = outEntry.illegal;
    assign outDestReg   = outEntry.dest[REG_ADDR_WIDTH-1:0];

    // Upper entry bits beyond the configured widths are always zero and never leave the stage.
    assign unusedOutEntryBits = ^outEntry;

`ifdef ALU_STAGE_STATS_EN
    // Transfers in a flush cycle still reach EX/MEM, so they are counted like any other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCount      <= '0;
            illegalCount <= '0;
        end else if (transfer) begin
            if (opCount != '1) begin
                opCount <= opCount + 32'd1;
            end
            if (outEntry.illegal && (illegalCount != '1)) begin
                illegalCount <= illegalCount + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed self-checking bench for alu_execute_stage (optionally with ALU_STAGE_STATS_EN).
module tb_alu_execute_stage;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [3:0]  controlOpALU;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [4:0]  destReg;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluResult;
    logic        zeroFlag;
    logic        overflowFlag;
    logic        illegalOp;
    logic [4:0]  outDestReg;
`ifdef ALU_STAGE_STATS_EN
    logic [31:0] opCount;
    logic [15:0] illegalCount;
`endif

    int total = 0;
    int bad   = 0;

    alu_execute_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inValid      (inValid),
        .inReady      (inReady),
        .controlOpALU (controlOpALU),
        .operandA     (operandA),
        .operandB     (operandB),
        .destReg      (destReg),
        .flush        (flush),
        .outValid     (outValid),
        .outReady     (outReady),
        .aluResult    (aluResult),
        .zeroFlag     (zeroFlag),
        .overflowFlag (overflowFlag),
        .illegalOp    (illegalOp),
        .outDestReg   (outDestReg)
`ifdef ALU_STAGE_STATS_EN
        ,
        .opCount      (opCount),
        .illegalCount (illegalCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic [3:0] code,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest);
        inValid      = valid;
        controlOpALU = code;
        operandA     = a;
        operandB     = b;
        destReg      = dest;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] res, input logic zero,
                               input logic ovf, input logic ill, input logic [4:0] dest);
        checkOutput({tag, ".valid"}, 64'(outValid), 64'd1);
        checkOutput({tag, ".result"}, 64'(aluResult), 64'(res));
        checkOutput({tag, ".zero"}, 64'(zeroFlag), 64'(zero));
        checkOutput({tag, ".ovf"}, 64'(overflowFlag), 64'(ovf));
        checkOutput({tag, ".illegal"}, 64'(illegalOp), 64'(ill));
        checkOutput({tag, ".dest"}, 64'(outDestReg), 64'(dest));
    endtask

    initial begin
        rst_n    = 1'b1;
        flush    = 1'b0;
        outReady = 1'b0;
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset.outValid", 64'(outValid), 64'd0);
        checkOutput("reset.inReady", 64'(inReady), 64'd1);
        checkOutput("reset.aluResult", 64'(aluResult), 64'd0);
        checkOutput("reset.flags", 64'({zeroFlag, overflowFlag, illegalOp}), 64'd0);
        checkOutput("reset.outDestReg", 64'(outDestReg), 64'd0);

        // Streaming directed ops with the consumer always ready
        @(negedge clk);
        rst_n    = 1'b1;
        outReady = 1'b1;
        applyStimulus(1'b1, 4'b0010, 32'd7, 32'd5, 5'd3);
        @(negedge clk);
        checkResult("add7p5", 32'd12, 1'b0, 1'b0, 1'b0, 5'd3);
        checkOutput("add7p5.inReady", 64'(inReady), 64'd1);
        applyStimulus(1'b1, 4'b0110, 32'd5, 32'd5, 5'd4);
        @(negedge clk);
        checkResult("sub5m5", 32'd0, 1'b1, 1'b0, 1'b0, 5'd4);
        applyStimulus(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd5);
        @(negedge clk);
        checkResult("sltNeg", 32'd1, 1'b0, 1'b0, 1'b0, 5'd5);
        applyStimulus(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd6);
        @(negedge clk);
        checkResult("addOvf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd6);
        applyStimulus(1'b1, 4'b1111, 32'd3, 32'd4, 5'd7);
        @(negedge clk);
        checkResult("illegal", 32'd0, 1'b1, 1'b0, 1'b1, 5'd7);
        applyStimulus(1'b1, 4'b0110, 32'h8000_0000, 32'd1, 5'd8);
        @(negedge clk);
        checkResult("subOvf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd8);
        applyStimulus(1'b1, 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd9);
        @(negedge clk);
        checkResult("and", 32'h00F0_000F, 1'b0, 1'b0, 1'b0, 5'd9);
        applyStimulus(1'b1, 4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd10);
        @(negedge clk);
        checkResult("or", 32'hFFF0_0FFF, 1'b0, 1'b0, 1'b0, 5'd10);
        applyStimulus(1'b1, 4'b1100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd11);
        @(negedge clk);
        checkResult("nor", 32'h000F_F000, 1'b0, 1'b0, 1'b0, 5'd11);
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        checkOutput("drain.outValid", 64'(outValid), 64'd0);

        // Backpressure: A and B fill the stage, C must wait
        outReady = 1'b0;
        applyStimulus(1'b1, 4'b0010, 32'd1, 32'd1, 5'd1);
        @(negedge clk);
        checkResult("bpA", 32'd2, 1'b0, 1'b0, 1'b0, 5'd1);
        checkOutput("bpA.inReady", 64'(inReady), 64'd1);
        applyStimulus(1'b1, 4'b0010, 32'd2, 32'd2, 5'd2);
        @(negedge clk);
        checkOutput("bpFull.inReady", 64'(inReady), 64'd0);
        checkResult("bpHoldA", 32'd2, 1'b0, 1'b0, 1'b0, 5'd1);
        applyStimulus(1'b1, 4'b0010, 32'd3, 32'd3, 5'd3);
        @(negedge clk);
        checkOutput("bpC.inReady", 64'(inReady), 64'd0);
        checkResult("bpStillA", 32'd2, 1'b0, 1'b0, 1'b0, 5'd1);
        outReady = 1'b1;
        @(negedge clk);
        checkResult("bpB", 32'd4, 1'b0, 1'b0, 1'b0, 5'd2);
        checkOutput("bpB.inReady", 64'(inReady), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        checkResult("bpC", 32'd6, 1'b0, 1'b0, 1'b0, 5'd3);
        @(negedge clk);
        checkOutput("bpDone.outValid", 64'(outValid), 64'd0);

        // Full throughput: one result per cycle
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'b0010, 32'(i), 32'd100, 5'(i));
            @(negedge clk);
            checkResult($sformatf("thru%0d", i), 32'(i + 100), 1'b0, 1'b0, 1'b0, 5'(i));
            checkOutput($sformatf("thru%0d.inReady", i), 64'(inReady), 64'd1);
        end
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        checkOutput("thruDone.outValid", 64'(outValid), 64'd0);

        // Flush while full, with op D offered in the same cycle
        outReady = 1'b0;
        applyStimulus(1'b1, 4'b0000, 32'hFF, 32'h0F, 5'd5);
        @(negedge clk);
        checkResult("flA", 32'h0F, 1'b0, 1'b0, 1'b0, 5'd5);
        applyStimulus(1'b1, 4'b0001, 32'hF0, 32'h0F, 5'd6);
        @(negedge clk);
        checkOutput("flFull.inReady", 64'(inReady), 64'd0);
        flush = 1'b1;
        applyStimulus(1'b1, 4'b0010, 32'h100, 32'h23, 5'd7);
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        checkOutput("flush.outValid", 64'(outValid), 64'd0);
        checkOutput("flush.inReady", 64'(inReady), 64'd1);
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("flushNoD1.outValid", 64'(outValid), 64'd0);
        @(negedge clk);
        checkOutput("flushNoD2.outValid", 64'(outValid), 64'd0);
        applyStimulus(1'b1, 4'b0010, 32'd9, 32'd9, 5'd8);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        checkResult("postFlushE", 32'd18, 1'b0, 1'b0, 1'b0, 5'd8);
        @(negedge clk);

        // Asynchronous reset in the middle of a stream
        outReady = 1'b0;
        applyStimulus(1'b1, 4'b0010, 32'd5, 32'd6, 5'd9);
        @(negedge clk);
        checkResult("preRst", 32'd11, 1'b0, 1'b0, 1'b0, 5'd9);
        applyStimulus(1'b1, 4'b0010, 32'd1, 32'd2, 5'd10);
        @(negedge clk);
        checkOutput("preRst.inReady", 64'(inReady), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRst.outValid", 64'(outValid), 64'd0);
        checkOutput("midRst.inReady", 64'(inReady), 64'd1);
        checkOutput("midRst.aluResult", 64'(aluResult), 64'd0);
        checkOutput("midRst.outDestReg", 64'(outDestReg), 64'd0);
`ifdef ALU_STAGE_STATS_EN
        checkOutput("midRst.opCount", 64'(opCount), 64'd0);
        checkOutput("midRst.illegalCount", 64'(illegalCount), 64'd0);
`endif
        @(negedge clk);
        rst_n    = 1'b1;
        outReady = 1'b1;
        applyStimulus(1'b1, 4'b1010, 32'd1, 32'd1, 5'd12);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        checkResult("postRstIllegal", 32'd0, 1'b1, 1'b0, 1'b1, 5'd12);
        @(negedge clk);
        checkOutput("postRst.outValid", 64'(outValid), 64'd0);
`ifdef ALU_STAGE_STATS_EN
        checkOutput("stats.opCount", 64'(opCount), 64'd1);
        checkOutput("stats.illegalCount", 64'(illegalCount), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_execute_stage.md
Name: alu_execute_stage

Overview:
- EX-stage block directly downstream of the ALU control decoder; consumes its 4-bit ALU control code plus the two operands.
- Computes the result and registers it toward EX/MEM behind a valid/ready handshake with a 2-entry skid buffer, so inReady is a registered signal.
- Supports a pipeline flush and flags illegal control codes.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits (>= 2).
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- inValid  input  1  upstream presents an operation.
- inReady  output  1  stage can accept; equals NOT skid-entry-valid (registered).
- controlOpALU  input  4  ALU control code from the decoder.
- operandA  input  DATA_WIDTH  first operand.
- operandB  input  DATA_WIDTH  second operand.
- destReg  input  REG_ADDR_WIDTH  destination register, passed through.
- flush  input  1  squash all held and incoming operations.
- outValid  output  1  result entry valid.
- outReady  input  1  EX/MEM accepts the result.
- aluResult  output  DATA_WIDTH  registered result.
- zeroFlag  output  1  aluResult == 0.
- overflowFlag  output  1  signed overflow on add/sub; 0 otherwise.
- illegalOp  output  1  code not in the supported set.
- outDestReg  output  REG_ADDR_WIDTH  registered destReg.

Behaviour:
- Op codes:
  - 0010 add: A+B mod 2^W.
  - 0110 sub: A-B mod 2^W.
  - 0000 and.
  - 0001 or.
  - 0111 slt: signed A<B gives 1, else 0, zero-extended.
  - 1100 nor.
  - Any other code: result 0, illegalOp=1, overflow 0.
- overflowFlag:
  - add: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from A.
- Registered fields: zeroFlag, overflowFlag, illegalOp and outDestReg are computed at accept time and stored with the entry.
- Reset: outValid=0, inReady=1, aluResult=0, all flags 0, outDestReg=0, state EMPTY.
- Handshake:
  - Accept = inValid & inReady.
  - Output transfer = outValid & outReady.
  - Latency is 1 cycle: an operation accepted at edge N is visible on the outputs after edge N with outValid=1.
- FSM states:
  - EMPTY: no entry.
  - BUSY: output entry only.
  - FULL: output and skid entries; inReady=0.
- Transitions (when flush=0):
  - EMPTY + accept -> BUSY.
  - BUSY + accept + transfer -> BUSY; new result replaces the output entry.
  - BUSY + accept + no transfer -> FULL; new result goes to the skid entry.
  - BUSY + transfer + no accept -> EMPTY.
  - FULL + transfer -> BUSY; the skid entry moves to output.
  - FULL + no transfer -> FULL, contents held.
- Ordering: results leave strictly in accept order. No entry is dropped or duplicated while flush=0.
- Output stability: while outValid=1 and outReady=0, all outputs stay stable.
- flush:
  - Flush has priority over everything else.
  - At the next edge the state becomes EMPTY, outValid=0, inReady=1.
  - An operation presented during the flush cycle is discarded.
  - A transfer in the flush cycle still counts downstream; the stage does not retract it.
- Reset mid-operation: all entries are lost immediately and the stage returns to reset values.
- Data regs: aluResult and the flags may hold stale values when outValid=0. They are reset to 0 only by rst_n.

Optional Feature:
- Macro ALU_STAGE_STATS_EN.
- When defined, adds two output ports:
  - opCount: 32 bits, counts output transfers.
  - illegalCount: 16 bits, counts output transfers with illegalOp=1.
- Both counters:
  - Reset to 0.
  - Saturate at all-ones.
  - Not cleared by flush.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - Enum alu_op_t with codes ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111, NOR=1100.
  - Enum stage_state_t with EMPTY, BUSY, FULL.
  - Struct alu_entry_t holding result, zero, overflow, illegal and dest.
- Sub-module alu_core: purely combinational; takes code and operands, returns an alu_entry_t. The stage module owns the FSM and the two entry registers.

Test Plan:
- add/sub/slt: ADD 7+5 -> aluResult=12, zero=0. SUB 5-5 -> result 0, zero=1. SLT 0xFFFFFFFF vs 1 -> result 1. All with outValid one cycle after accept.
- Overflow and illegal: ADD 0x7FFFFFFF+1 -> result 0x80000000, overflowFlag=1. Code 1111 -> result 0, illegalOp=1.
- Backpressure:
  - Hold outReady=0 and push ops A, B -> FULL, inReady=0.
  - Third op C is not accepted.
  - Release outReady -> A, B, C emerge in order with no loss.
- Full throughput: inValid=outReady=1 for 10 ops -> 10 results on consecutive cycles, inReady stays 1.
- Flush: in FULL state pulse flush while offering op D -> next cycle outValid=0, inReady=1, D never appears.
- Reset: assert rst_n=0 mid-stream asynchronously -> outputs go to zero and state to EMPTY immediately. With ALU_STAGE_STATS_EN, counters read 0.
